// File: rtl/j1_uart_boot_loader.sv
// UART boot loader: holds the J1 core in reset, loads a framed image into code RAM, releases the core on a good checksum.
// Latency: each RAM write issues the cycle after a word's 4th byte; the core is released the cycle after the CHK byte.
// Backpressure: none, every rx_valid strobe is accepted. Optional BOOT_TIMEOUT_EN releases the core if no frame starts.
module j1_uart_boot_loader #(
  parameter int         ADDR_W      = 13,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    SYNC, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len_in;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  xor_acc;
  logic        to_hit;

  assign len_in = {rx_data, len_lo};

`ifdef BOOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_armed;

  // Armed only until the first byte after reset; a started frame never times out.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      to_cnt   <= '0;
      to_armed <= 1'b1;
    end else begin
      if (rx_valid)
        to_armed <= 1'b0;
      if (to_armed && state == SYNC)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = to_armed && (state == SYNC) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // TIMEOUT_CYC only matters with BOOT_TIMEOUT_EN; this is constant false.
  assign to_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      state <= SYNC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // ERR is a one-cycle stop on the way back to SYNC; a byte arriving then is still hunted for sync.
      SYNC, ERR: begin
        if (state == ERR)
          state_nxt = SYNC;
        if (rx_valid && rx_data == SYNC_BYTE)
          state_nxt = LEN_LO;
        else if (to_hit)
          state_nxt = DONE;
      end
      LEN_LO: begin
        if (rx_valid)
          state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (rx_valid) begin
          if (len_in == 16'd0)
            state_nxt = CHK;
          else if ({1'b0, len_in} > MAX_LEN)
            state_nxt = ERR;
          else
            state_nxt = DATA;
        end
      end
      DATA: begin
        if (rx_valid && byte_idx == 2'd3 && word_cnt == 16'd1)
          state_nxt = CHK;
      end
      CHK: begin
        if (rx_valid)
          state_nxt = (rx_data == xor_acc) ? DONE : ERR;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    cpu_rst   = 1'b1;
    boot_done = 1'b0;
    if (state == DONE) begin
      cpu_rst   = 1'b0;
      boot_done = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      boot_err  <= 1'b0;
      len_lo    <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      xor_acc   <= '0;
    end else begin
      mem_we <= 1'b0;

      // Advance only once more data follows, so the last word of a full-size image leaves mem_addr at the top.
      if (mem_we && state == DATA)
        mem_addr <= mem_addr + 1'b1;

      if (rx_valid) begin
        case (state)
          LEN_LO: begin
            len_lo  <= rx_data;
            xor_acc <= xor_acc ^ rx_data;
          end
          LEN_HI: begin
            word_cnt <= len_in;
            byte_idx <= 2'd0;
            xor_acc  <= xor_acc ^ rx_data;
          end
          DATA: begin
            xor_acc  <= xor_acc ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                mem_wdata <= {rx_data, word_buf};
                mem_we    <= 1'b1;
                word_cnt  <= word_cnt - 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end

      if (state_nxt == LEN_LO && state != LEN_LO) begin
        mem_addr <= '0;
        xor_acc  <= '0;
      end

      if (state_nxt == ERR)
        boot_err <= 1'b1;
      else if (state_nxt == DONE && state != DONE)
        boot_err <= 1'b0;
    end
  end

endmodule
